// File: rtl/relprime_pkg.sv
// relprime_pkg: shared types and constants for the relprime coprocessor.
//   state_t : engine FSM states
//   M_START : first candidate tried for m
package relprime_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STEP,
    CHECK,
    FINISH
  } state_t;

  localparam int M_START = 2;

endpackage

// File: rtl/gcd_step.sv
// gcd_step: one iteration of subtraction-based Euclid, purely combinational.
// Ports:
//   a, b           in   WIDTH  current Euclid operands (both nonzero in use)
//   a_next, b_next out  WIDTH  operands after subtracting the smaller from the larger
//   eq             out  1      a == b (Euclid finished, a holds the gcd)
//   is_one         out  1      a == 1 (gcd is one when eq is also set)
module gcd_step
  import relprime_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next,
  output logic             eq,
  output logic             is_one
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    a_next = a;
    b_next = b;
    if (a > b) begin
      a_next = a - b;
    end else if (b > a) begin
      b_next = b - a;
    end
  end

  assign eq     = (a == b);
  assign is_one = (a == WIDTH'(1));

endmodule

// File: rtl/relprime_engine.sv
// relprime_engine: start/done coprocessor returning the smallest m >= 2 with
// gcd(n, m) == 1. Candidates are tried in increasing order; each runs a
// subtraction Euclid, one subtract per clock.
// Ports:
//   CLK     in   1      clock, rising edge
//   RST_N   in   1      asynchronous active-low reset
//   start   in   1      request, sampled only while idle
//   n_in    in   WIDTH  operand n, captured on an accepted start
//   busy    out  1      high from the cycle after accept until the done cycle
//   done    out  1      one-cycle pulse when result/err are valid
//   err     out  1      no valid result (n == 0 or candidate overflow)
//   result  out  WIDTH  smallest coprime m, 0 on err; held until next run
//   cycles  out  CYC_W  accept-to-done clock count, saturating, held
// Configuration:
//   RELPRIME_CYCLE_COUNT_EN  when defined, adds the CYC_W parameter, the
//                            cycles port and its counter.
module relprime_engine
  import relprime_pkg::*;
#(
  parameter int WIDTH = 16
`ifdef RELPRIME_CYCLE_COUNT_EN
  ,
  parameter int CYC_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef RELPRIME_CYCLE_COUNT_EN
  ,
  output logic [CYC_W-1:0] cycles
`endif
);

  state_t           state;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic             eq;
  logic             is_one;

  gcd_step #(.WIDTH(WIDTH)) u_gcd_step (
    .a      (a),
    .b      (b),
    .a_next (a_next),
    .b_next (b_next),
    .eq     (eq),
    .is_one (is_one)
  );

  // done is registered: it is raised on the edge entering FINISH and falls
  // on the following edge, giving a pulse that coincides with the FINISH state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      n_r    <= '0;
      m      <= '0;
      a      <= '0;
      b      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_r   <= n_in;
            m     <= WIDTH'(M_START);
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (n_r == '0) begin
            err    <= 1'b1;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FINISH;
          end else begin
            a     <= n_r;
            b     <= m;
            state <= STEP;
          end
        end
        STEP: begin
          if (eq) begin
            state <= CHECK;
          end else begin
            a <= a_next;
            b <= b_next;
          end
        end
        CHECK: begin
          if (is_one) begin
            result <= m;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FINISH;
          end else if (m == '1) begin
            // No further candidate representable in WIDTH bits.
            err    <= 1'b1;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FINISH;
          end else begin
            m     <= m + WIDTH'(1);
            state <= SETUP;
          end
        end
        FINISH: begin
          // start is deliberately not sampled here; next accept is in IDLE.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RELPRIME_CYCLE_COUNT_EN
  // Counts every clock while busy, so the final value equals the number of
  // edges from the accept edge up to the edge that raises done.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycles <= '0;
    end else if (state == IDLE && start) begin
      cycles <= '0;
    end else if (busy && cycles != '1) begin
      cycles <= cycles + CYC_W'(1);
    end
  end
`endif

endmodule
